// File: rtl/gbt_link_reset_sequencer.sv
// GBT link bring-up sequencer: PLL reset, lock wait with retries, LOS filtering,
// staggered release of the three clock-domain resets, and loss-driven fallback.
module gbt_link_reset_sequencer #(
  parameter int PLL_RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT      = 4096,
  parameter int LOS_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES    = 8,
  parameter int MAX_RETRIES       = 7
) (
  input  logic       clk_ik,
  input  logic       rst_irn,
  input  logic       ext_pll_ready_i,
  input  logic       gbt_pll_locked_i,
  input  logic       los_i,
  input  logic       restart_i,
  output logic       gbt_pll_rst_o,
  output logic [2:0] domain_rst_o,
  output logic       link_ready_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [2:0] retry_cnt_o,
  output logic [7:0] los_event_cnt_o
);

  localparam int M_A     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int M_B     = (LOS_STABLE_CYCLES > 2 * STAGGER_CYCLES) ? LOS_STABLE_CYCLES : 2 * STAGGER_CYCLES;
  localparam int CNT_MAX = (M_A > M_B) ? M_A : M_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_EXT  = 3'd1,
    S_PLL_RST   = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_WAIT_LOS  = 3'd4,
    S_RELEASE   = 3'd5,
    S_RUN       = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic             w_cnt_clr;
  logic [2:0]       r_retry, w_retry_next, w_retry_inc;
  logic [7:0]       r_los_evt, w_los_evt_next;
  logic [2:0]       r_sync_meta, r_sync;
  logic             w_ext, w_lock, w_los;
  logic             r_pll_rst, r_link_ready, r_fault;
  logic [2:0]       r_dom, w_dom_next;

  assign w_ext       = r_sync[0];
  assign w_lock      = r_sync[1];
  assign w_los       = r_sync[2];
  assign w_cnt_inc   = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : r_cnt + 1'b1;
  assign w_retry_inc = r_retry + 3'd1;

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_cnt_clr    = 1'b0;
    case (r_state)
      S_RESET: w_state_next = S_WAIT_EXT;
      S_FAULT: begin
        if (restart_i) begin
          w_state_next = S_WAIT_EXT;
          w_retry_next = 3'd0;
        end
      end
      default: begin
        // Loss conditions override the normal progression, ext-ready loss first.
        if (!w_ext) begin
          w_state_next = S_WAIT_EXT;
        end else if (!w_lock && (r_state inside {S_WAIT_LOS, S_RELEASE, S_RUN})) begin
          w_state_next = S_PLL_RST;
        end else if (w_los && (r_state inside {S_RELEASE, S_RUN})) begin
          w_state_next = S_WAIT_LOS;
        end else begin
          case (r_state)
            S_WAIT_EXT: w_state_next = S_PLL_RST;
            S_PLL_RST: begin
              if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) w_state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
              if (w_lock) begin
                w_state_next = S_WAIT_LOS;
              end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                w_retry_next = w_retry_inc;
                w_state_next = (w_retry_inc == 3'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
              end
            end
            S_WAIT_LOS: begin
              if (w_los) w_cnt_clr = 1'b1;
              else if (r_cnt == CNT_W'(LOS_STABLE_CYCLES - 1)) w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
              if (r_cnt == CNT_W'(2 * STAGGER_CYCLES)) w_state_next = S_RUN;
            end
            default: ;
          endcase
        end
      end
    endcase
    if (w_state_next == S_RUN) w_retry_next = 3'd0;
  end

  always_comb begin
    w_cnt_next = w_cnt_inc;
    if (w_state_next != r_state || w_cnt_clr) w_cnt_next = '0;
    w_los_evt_next = r_los_evt;
    if (r_state == S_RUN && w_state_next != S_RUN && r_los_evt != 8'hFF)
      w_los_evt_next = r_los_evt + 8'd1;
    // Outputs are computed from the next state so the registered copies line up with state_o.
    case (w_state_next)
      S_RELEASE: w_dom_next = {w_cnt_next < CNT_W'(2 * STAGGER_CYCLES),
                               w_cnt_next < CNT_W'(STAGGER_CYCLES), 1'b0};
      S_RUN:     w_dom_next = 3'b000;
      default:   w_dom_next = 3'b111;
    endcase
  end

  always_ff @(posedge clk_ik or negedge rst_irn) begin
    if (!rst_irn) begin
      r_sync_meta  <= 3'b000;
      r_sync       <= 3'b000;
      r_state      <= S_RESET;
      r_cnt        <= '0;
      r_retry      <= 3'd0;
      r_los_evt    <= 8'd0;
      r_pll_rst    <= 1'b1;
      r_dom        <= 3'b111;
      r_link_ready <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_sync_meta  <= {los_i, gbt_pll_locked_i, ext_pll_ready_i};
      r_sync       <= r_sync_meta;
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_retry      <= w_retry_next;
      r_los_evt    <= w_los_evt_next;
      r_pll_rst    <= (w_state_next == S_PLL_RST) || (w_state_next == S_FAULT);
      r_dom        <= w_dom_next;
      r_link_ready <= (w_state_next == S_RUN);
      r_fault      <= (w_state_next == S_FAULT);
    end
  end

  assign gbt_pll_rst_o   = r_pll_rst;
  assign domain_rst_o    = r_dom;
  assign link_ready_o    = r_link_ready;
  assign fault_o         = r_fault;
  assign state_o         = r_state;
  assign retry_cnt_o     = r_retry;
  assign los_event_cnt_o = r_los_evt;

endmodule

// File: tb/tb_gbt_link_reset_sequencer.sv
// Directed bench for gbt_link_reset_sequencer using shortened timing parameters.
module tb_gbt_link_reset_sequencer;

  logic       clk_ik = 1'b0;
  logic       rst_irn = 1'b1;
  logic       ext_pll_ready_i = 1'b0;
  logic       gbt_pll_locked_i = 1'b0;
  logic       los_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       gbt_pll_rst_o;
  logic [2:0] domain_rst_o;
  logic       link_ready_o;
  logic       fault_o;
  logic [2:0] state_o;
  logic [2:0] retry_cnt_o;
  logic [7:0] los_event_cnt_o;

  int total = 0;
  int bad   = 0;

  gbt_link_reset_sequencer #(
    .PLL_RST_CYCLES(8), .LOCK_TIMEOUT(100), .LOS_STABLE_CYCLES(16),
    .STAGGER_CYCLES(4), .MAX_RETRIES(3)
  ) dut (
    .clk_ik(clk_ik), .rst_irn(rst_irn), .ext_pll_ready_i(ext_pll_ready_i),
    .gbt_pll_locked_i(gbt_pll_locked_i), .los_i(los_i), .restart_i(restart_i),
    .gbt_pll_rst_o(gbt_pll_rst_o), .domain_rst_o(domain_rst_o),
    .link_ready_o(link_ready_o), .fault_o(fault_o), .state_o(state_o),
    .retry_cnt_o(retry_cnt_o), .los_event_cnt_o(los_event_cnt_o)
  );

  always #5 clk_ik = ~clk_ik;

  task automatic step();
    @(posedge clk_ik);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (state_o == s) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    ok = (state_o == s);
  endtask

  task automatic test_reset();
    #2 rst_irn = 1'b0;
    #1;
    total++;
    if ({state_o, gbt_pll_rst_o, domain_rst_o, link_ready_o, fault_o} !== {3'd0, 1'b1, 3'b111, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got state=%0d pll_rst=%0b dom=%b ready=%0b fault=%0b want 0 1 111 0 0",
               state_o, gbt_pll_rst_o, domain_rst_o, link_ready_o, fault_o);
    end
    total++;
    if ({retry_cnt_o, los_event_cnt_o} !== 11'd0) begin
      bad++;
      $display("FAIL reset_counters: got retry=%0d los_evt=%0d want 0 0", retry_cnt_o, los_event_cnt_o);
    end
    step(); step();
    rst_irn = 1'b1;
    step();
    total++;
    if (state_o !== 3'd1) begin
      bad++;
      $display("FAIL reset_exit: got state=%0d want 1", state_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    bit ok;
    int n;
    ext_pll_ready_i = 1'b1;
    wait_state(3'd2, 20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL nom_reach_pll_rst: got state=%0d want 2", state_o); end
    n = 0;
    while (gbt_pll_rst_o === 1'b1 && n < 50) begin n++; step(); end
    total++;
    if (n != 8) begin bad++; $display("FAIL nom_pll_rst_len: got %0d want 8", n); end
    total++;
    if (state_o !== 3'd3) begin bad++; $display("FAIL nom_wait_lock: got state=%0d want 3", state_o); end
    for (int i = 0; i < 20; i++) step();
    gbt_pll_locked_i = 1'b1;
    wait_state(3'd4, 10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL nom_reach_wait_los: got state=%0d want 4", state_o); end
    n = 0;
    while (state_o === 3'd4 && n < 50) begin n++; step(); end
    total++;
    if (n != 16 || state_o !== 3'd5) begin
      bad++; $display("FAIL nom_los_stable: got %0d cycles then state=%0d want 16 then 5", n, state_o);
    end
    total++;
    if (domain_rst_o !== 3'b110) begin bad++; $display("FAIL nom_dom_entry: got %b want 110", domain_rst_o); end
    for (int i = 0; i < 4; i++) step();
    total++;
    if (domain_rst_o !== 3'b100) begin bad++; $display("FAIL nom_dom_plus4: got %b want 100", domain_rst_o); end
    for (int i = 0; i < 4; i++) step();
    total++;
    if (domain_rst_o !== 3'b000 || state_o !== 3'd5) begin
      bad++; $display("FAIL nom_dom_plus8: got dom=%b state=%0d want 000 5", domain_rst_o, state_o);
    end
    step();
    total++;
    if ({state_o, link_ready_o, domain_rst_o, retry_cnt_o} !== {3'd6, 1'b1, 3'b000, 3'd0}) begin
      bad++; $display("FAIL nom_run: got state=%0d ready=%0b dom=%b retry=%0d want 6 1 000 0",
                      state_o, link_ready_o, domain_rst_o, retry_cnt_o);
    end
    $display("test_nominal done");
  endtask

  task automatic test_run_loss();
    int n;
    los_i = 1'b1;
    gbt_pll_locked_i = 1'b0;
    n = 0;
    while (state_o === 3'd6 && n < 10) begin n++; step(); end
    total++;
    if (state_o !== 3'd2 || domain_rst_o !== 3'b111 || link_ready_o !== 1'b0) begin
      bad++; $display("FAIL run_loss_state: got state=%0d dom=%b ready=%0b want 2 111 0",
                      state_o, domain_rst_o, link_ready_o);
    end
    total++;
    if (los_event_cnt_o !== 8'd1) begin bad++; $display("FAIL run_loss_evt: got %0d want 1", los_event_cnt_o); end
    $display("test_run_loss done");
  endtask

  task automatic test_los_filter();
    bit ok;
    bit seen_release;
    int n;
    gbt_pll_locked_i = 1'b1;
    wait_state(3'd4, 40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL los_reach_wait_los: got state=%0d want 4", state_o); end
    seen_release = 1'b0;
    for (int p = 0; p < 6; p++) begin
      los_i = (p % 2 == 1);
      for (int i = 0; i < 10; i++) begin
        step();
        if (state_o === 3'd5) seen_release = 1'b1;
      end
    end
    total++;
    if (seen_release || state_o !== 3'd4) begin
      bad++; $display("FAIL los_toggle: got release_seen=%0b state=%0d want 0 4", seen_release, state_o);
    end
    los_i = 1'b0;
    n = 0;
    while (state_o !== 3'd5 && n < 40) begin n++; step(); end
    total++;
    if (n != 18) begin bad++; $display("FAIL los_clean_len: got %0d want 18", n); end
    $display("test_los_filter done");
  endtask

  task automatic test_async_reset();
    step(); step();
    #2 rst_irn = 1'b0;
    #1;
    total++;
    if ({state_o, gbt_pll_rst_o, domain_rst_o, link_ready_o, fault_o, retry_cnt_o, los_event_cnt_o}
        !== {3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0}) begin
      bad++; $display("FAIL async_reset: got state=%0d pll_rst=%0b dom=%b ready=%0b fault=%0b retry=%0d evt=%0d want 0 1 111 0 0 0 0",
                      state_o, gbt_pll_rst_o, domain_rst_o, link_ready_o, fault_o, retry_cnt_o, los_event_cnt_o);
    end
    step();
    rst_irn = 1'b1;
    step();
    total++;
    if (state_o !== 3'd1) begin bad++; $display("FAIL async_reset_restart: got state=%0d want 1", state_o); end
    $display("test_async_reset done");
  endtask

  task automatic test_timeout_fault();
    bit ok;
    int n;
    gbt_pll_locked_i = 1'b0;
    los_i = 1'b0;
    wait_state(3'd3, 40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL to_reach_wait_lock: got state=%0d want 3", state_o); end
    for (int a = 1; a <= 3; a++) begin
      n = 0;
      while (state_o === 3'd3 && n < 200) begin n++; step(); end
      total++;
      if (n != 100 || retry_cnt_o !== 3'(a)) begin
        bad++; $display("FAIL to_attempt%0d: got %0d cycles retry=%0d want 100 %0d", a, n, retry_cnt_o, a);
      end
      if (a < 3) begin
        total++;
        if (state_o !== 3'd2) begin bad++; $display("FAIL to_retry%0d_state: got %0d want 2", a, state_o); end
        wait_state(3'd3, 20, ok);
      end
    end
    total++;
    if ({state_o, fault_o, gbt_pll_rst_o, domain_rst_o} !== {3'd7, 1'b1, 1'b1, 3'b111}) begin
      bad++; $display("FAIL to_fault: got state=%0d fault=%0b pll_rst=%0b dom=%b want 7 1 1 111",
                      state_o, fault_o, gbt_pll_rst_o, domain_rst_o);
    end
    ext_pll_ready_i = 1'b0;
    gbt_pll_locked_i = 1'b1;
    los_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    total++;
    if (state_o !== 3'd7 || fault_o !== 1'b1) begin
      bad++; $display("FAIL fault_hold: got state=%0d fault=%0b want 7 1", state_o, fault_o);
    end
    ext_pll_ready_i = 1'b1;
    gbt_pll_locked_i = 1'b0;
    los_i = 1'b0;
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    total++;
    if ({state_o, retry_cnt_o, fault_o} !== {3'd1, 3'd0, 1'b0}) begin
      bad++; $display("FAIL restart: got state=%0d retry=%0d fault=%0b want 1 0 0", state_o, retry_cnt_o, fault_o);
    end
    $display("test_timeout_fault done");
  endtask

  task automatic test_ext_loss();
    bit ok;
    int n;
    wait_state(3'd3, 40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ext_reach_wait_lock: got state=%0d want 3", state_o); end
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    total++;
    if (state_o !== 3'd3 || retry_cnt_o !== 3'd0) begin
      bad++; $display("FAIL restart_ignored: got state=%0d retry=%0d want 3 0", state_o, retry_cnt_o);
    end
    ext_pll_ready_i = 1'b0;
    n = 0;
    while (state_o === 3'd3 && n < 10) begin n++; step(); end
    total++;
    if ({state_o, domain_rst_o, gbt_pll_rst_o, n[3:0]} !== {3'd1, 3'b111, 1'b0, 4'd3}) begin
      bad++; $display("FAIL ext_loss: got state=%0d dom=%b pll_rst=%0b after %0d want 1 111 0 after 3",
                      state_o, domain_rst_o, gbt_pll_rst_o, n);
    end
    $display("test_ext_loss done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_run_loss();
    test_los_filter();
    test_async_reset();
    test_timeout_fault();
    test_ext_loss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gbt_link_reset_sequencer.md
GBT_LINK_RESET_SEQUENCER -- requirements
Module: gbt_link_reset_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_ik and rst_irn.
REQ-002 Parameters SHALL be, one per line, as follows.
- PLL_RST_CYCLES, 16, cycles gbt_pll_rst_o is held high.
- LOCK_TIMEOUT, 4096, cycles to wait for PLL lock.
- LOS_STABLE_CYCLES, 1024, consecutive los-free cycles required.
- STAGGER_CYCLES, 8, spacing between domain reset releases.
- MAX_RETRIES, 7, lock attempts before fault.
REQ-003 Ports SHALL be, one per line, as follows.
- clk_ik  in  1  free-running 100MHz clock.
- rst_irn  in  1  async active-low reset.
- ext_pll_ready_i  in  1  external PLL ready (async).
- gbt_pll_locked_i  in  1  GBT 40MHz PLL lock (async).
- los_i  in  1  optical loss of signal (async).
- restart_i  in  1  single-cycle pulse to leave FAULT.
- gbt_pll_rst_o  out  1  GBT PLL reset, active-high.
- domain_rst_o  out  3  [0]=100MHz, [1]=120MHz, [2]=40MHz domain resets, active-high.
- link_ready_o  out  1  sequence complete, link usable.
- fault_o  out  1  retry budget exhausted.
- state_o  out  3  current state encoding.
- retry_cnt_o  out  3  lock attempts in current bring-up.
- los_event_cnt_o  out  8  saturating count of RUN exits.

Function
REQ-004 Inputs ext_pll_ready_i, gbt_pll_locked_i and los_i SHALL each pass a 2-FF synchronizer; all decisions use synchronized values.
REQ-005 All outputs SHALL be registered.
REQ-006 State encoding SHALL be RESET=0, WAIT_EXT=1, PLL_RST=2, WAIT_LOCK=3, WAIT_LOS=4, RELEASE=5, RUN=6, FAULT=7.
REQ-007 RESET SHALL go to WAIT_EXT on the first clock after rst_irn deasserts.
REQ-008 WAIT_EXT SHALL go to PLL_RST when ext ready is 1, clearing the cycle counter.
REQ-009 PLL_RST SHALL hold gbt_pll_rst_o=1 for exactly PLL_RST_CYCLES cycles and then go to WAIT_LOCK.
REQ-010 In WAIT_LOCK, lock=1 SHALL move the block to WAIT_LOS.
REQ-011 In WAIT_LOCK, counter reaching LOCK_TIMEOUT SHALL increment retry_cnt and then go to FAULT if the new value equals MAX_RETRIES, else to PLL_RST.
REQ-012 In WAIT_LOS, any los=1 cycle SHALL clear the stability counter; LOS_STABLE_CYCLES consecutive los=0 cycles SHALL move the block to RELEASE.
REQ-013 RELEASE SHALL clear domain_rst_o[0] on entry, [1] STAGGER_CYCLES later and [2] 2*STAGGER_CYCLES later, then go to RUN one cycle after [2] clears.
REQ-014 RUN SHALL set link_ready_o=1 and clear retry_cnt.
REQ-015 Leaving RUN for any reason SHALL increment los_event_cnt, saturating at 255.
REQ-016 Loss conditions SHALL apply in every state except RESET and FAULT, with priority ext-ready loss > lock loss > los.
- ext ready=0: go to WAIT_EXT.
- Lock=0 in WAIT_LOS, RELEASE or RUN: go to PLL_RST with no retry increment.
- los=1 in RELEASE or RUN: go to WAIT_LOS.
REQ-017 On any transition into WAIT_EXT, PLL_RST, WAIT_LOCK or WAIT_LOS, domain_rst_o SHALL be 3'b111 and link_ready_o SHALL be 0 from the next cycle.
REQ-018 FAULT SHALL hold fault_o=1, gbt_pll_rst_o=1 and domain_rst_o=3'b111, ignoring all inputs except restart_i.
REQ-019 restart_i in FAULT SHALL clear retry_cnt and fault_o and go to WAIT_EXT; restart_i in any other state SHALL be ignored.
REQ-020 Counters SHALL be sized to hold their largest parameter and SHALL never wrap.

Reset
REQ-021 While rst_irn=0, outputs SHALL be as follows.
- state_o=0, gbt_pll_rst_o=1, domain_rst_o=3'b111.
- link_ready_o=0, fault_o=0.
- retry_cnt_o=0, los_event_cnt_o=0.
- Synchronizers and counters cleared.
REQ-022 Assertion of rst_irn mid-sequence SHALL force the reset values immediately, with no clock required.

Verification
Verification uses PLL_RST_CYCLES=8, LOCK_TIMEOUT=100, LOS_STABLE_CYCLES=16, STAGGER_CYCLES=4, MAX_RETRIES=3.
REQ-023 Nominal: ext ready=1, lock rises 20 cycles after PLL_RST exit, los=0.
- gbt_pll_rst_o high exactly 8 cycles.
- domain_rst_o bits clear at 4-cycle spacing.
- link_ready_o=1, state_o=6.
REQ-024 Lock never asserts.
- Three 100-cycle timeouts occur.
- retry_cnt_o steps 1, 2, 3.
- fault_o=1, state_o=7.
- restart_i pulse gives state_o=1, retry_cnt_o=0.
REQ-025 los toggles every 10 cycles in WAIT_LOS: RELEASE is never entered; after los is held low, RELEASE follows exactly 16 clean cycles (+2 sync).
REQ-026 In RUN, assert los_i and lock loss on the same cycle.
- The block goes to PLL_RST (lock priority).
- domain_rst_o=3'b111.
- los_event_cnt_o=1.
REQ-027 rst_irn is pulsed low during RELEASE: all outputs return to reset values asynchronously, and bring-up restarts from state_o=0.
